// File: rtl/udp_port_dispatch.sv
// UDP receive dispatcher: parses the 8-byte UDP header, looks up the destination port in a
// writable table and steers payload bytes to the matching channel, trimming padding via the length field.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | between datagrams, waiting for byte 0
// HDR     | header bytes k=1..7, port lookup at k=3, length at k=5
// PAYLOAD | forwarding payload bytes until remaining reaches 0
// DISCARD | ignoring bytes (dropped, malformed or padding) until data_en=0
// WAIT    | after reset, ignoring any datagram already in progress
module udp_port_dispatch #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     aclr,
    input  logic [7:0]               datain,
    input  logic                     data_en,
    input  logic                     cfg_we,
    input  logic [$clog2(NCH)-1:0]   cfg_addr,
    input  logic [15:0]              cfg_port,
    input  logic                     cfg_enable,
    output logic [7:0]               pl_data,
    output logic [NCH-1:0]           pl_en,
    output logic                     pl_sof,
    output logic                     pl_eof,
    output logic                     pl_abort,
    output logic                     busy,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam int AW = $clog2(NCH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_DISCARD = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [3:0]       k_q, k_d;
    logic [7:0]       dst_hi_q, dst_hi_d;
    logic [7:0]       len_hi_q, len_hi_d;
    logic [15:0]      rem_q, rem_d;
    logic [AW-1:0]    ch_q, ch_d;
    logic             first_q, first_d;

    logic [NCH-1:0]   tbl_en_q, tbl_en_d;
    logic [15:0]      tbl_port_q [NCH];
    logic [15:0]      tbl_port_d [NCH];

    logic [7:0]       pl_data_q, pl_data_d;
    logic [NCH-1:0]   pl_en_q, pl_en_d;
    logic             pl_sof_q, pl_sof_d;
    logic             pl_eof_q, pl_eof_d;
    logic             pl_abort_q, pl_abort_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] err_q, err_d;

    logic             drop_inc, err_inc;
    logic             hit;
    logic [AW-1:0]    hit_idx;
    logic [15:0]      dst_full, len_full;

    assign dst_full = {dst_hi_q, datain};
    assign len_full = {len_hi_q, datain};

    always_comb begin
        tbl_en_d   = tbl_en_q;
        tbl_port_d = tbl_port_q;
        if (cfg_we && (int'(cfg_addr) < NCH)) begin
            tbl_en_d[cfg_addr]   = cfg_enable;
            tbl_port_d[cfg_addr] = cfg_port;
        end
    end

    // Lookup uses registered table contents, so a same-cycle write is not seen; lowest index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (tbl_en_q[i] && (tbl_port_q[i] == dst_full)) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        dst_hi_d   = dst_hi_q;
        len_hi_d   = len_hi_q;
        rem_d      = rem_q;
        ch_d       = ch_q;
        first_d    = first_q;
        busy_d     = busy_q;
        pl_data_d  = 8'h00;
        pl_en_d    = '0;
        pl_sof_d   = 1'b0;
        pl_eof_d   = 1'b0;
        pl_abort_d = 1'b0;
        drop_inc   = 1'b0;
        err_inc    = 1'b0;

        case (state_q)
            S_WAIT: begin
                busy_d = 1'b0;
                if (!data_en) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                busy_d = 1'b0;
                if (data_en) begin
                    state_d = S_HDR;
                    k_d     = 4'd1;
                    busy_d  = 1'b1;
                end
            end

            S_HDR: begin
                if (!data_en) begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    k_d = k_q + 4'd1;
                    case (k_q)
                        4'd2: dst_hi_d = datain;
                        4'd3: begin
                            if (hit) begin
                                ch_d = hit_idx;
                            end else begin
                                drop_inc = 1'b1;
                                state_d  = S_DISCARD;
                            end
                        end
                        4'd4: len_hi_d = datain;
                        4'd5: begin
                            if (len_full < 16'd8) begin
                                err_inc = 1'b1;
                                state_d = S_DISCARD;
                            end else if (len_full == 16'd8) begin
                                state_d = S_DISCARD;
                            end else begin
                                rem_d = len_full - 16'd8;
                            end
                        end
                        4'd7: begin
                            state_d = S_PAYLOAD;
                            first_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            S_PAYLOAD: begin
                if (!data_en) begin
                    pl_abort_d = 1'b1;
                    err_inc    = 1'b1;
                    state_d    = S_IDLE;
                    busy_d     = 1'b0;
                end else begin
                    pl_en_d[ch_q] = 1'b1;
                    pl_data_d     = datain;
                    pl_sof_d      = first_q;
                    first_d       = 1'b0;
                    rem_d         = rem_q - 16'd1;
                    if (k_q != 4'd8) begin
                        k_d = k_q + 4'd1;
                    end
                    if (rem_q == 16'd1) begin
                        pl_eof_d = 1'b1;
                        state_d  = S_DISCARD;
                        busy_d   = 1'b0;
                    end
                end
            end

            // busy stays as entered: high for a dropped header, low after a completed payload
            S_DISCARD: begin
                if (!data_en) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_WAIT;
                busy_d  = 1'b0;
            end
        endcase

        drop_d = (drop_inc && (drop_q != {CNT_W{1'b1}})) ? drop_q + CNT_W'(1) : drop_q;
        err_d  = (err_inc  && (err_q  != {CNT_W{1'b1}})) ? err_q  + CNT_W'(1) : err_q;
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q    <= S_WAIT;
            k_q        <= '0;
            dst_hi_q   <= '0;
            len_hi_q   <= '0;
            rem_q      <= '0;
            ch_q       <= '0;
            first_q    <= 1'b0;
            tbl_en_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                tbl_port_q[i] <= '0;
            end
            pl_data_q  <= '0;
            pl_en_q    <= '0;
            pl_sof_q   <= 1'b0;
            pl_eof_q   <= 1'b0;
            pl_abort_q <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            dst_hi_q   <= dst_hi_d;
            len_hi_q   <= len_hi_d;
            rem_q      <= rem_d;
            ch_q       <= ch_d;
            first_q    <= first_d;
            tbl_en_q   <= tbl_en_d;
            tbl_port_q <= tbl_port_d;
            pl_data_q  <= pl_data_d;
            pl_en_q    <= pl_en_d;
            pl_sof_q   <= pl_sof_d;
            pl_eof_q   <= pl_eof_d;
            pl_abort_q <= pl_abort_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    assign pl_data  = pl_data_q;
    assign pl_en    = pl_en_q;
    assign pl_sof   = pl_sof_q;
    assign pl_eof   = pl_eof_q;
    assign pl_abort = pl_abort_q;
    assign busy     = busy_q;
    assign drop_cnt = drop_q;
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_udp_port_dispatch.sv
// Bench for udp_port_dispatch: directed datagrams plus random ones, checked against a
// datagram-level model of the header/length/port rules.
module tb_udp_port_dispatch;

    localparam int NCH   = 4;
    localparam int CNT_W = 3;
    localparam int AW    = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             aclr;
    logic [7:0]       datain;
    logic             data_en;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [15:0]      cfg_port;
    logic             cfg_enable;
    logic [7:0]       pl_data;
    logic [NCH-1:0]   pl_en;
    logic             pl_sof, pl_eof, pl_abort, busy;
    logic [CNT_W-1:0] drop_cnt, err_cnt;

    int checks = 0;
    int errors = 0;

    bit          men   [NCH];
    logic [15:0] mport [NCH];
    int          mdrop, merr;
    logic [7:0]  fixed_pl [$];

    udp_port_dispatch #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clock(clock), .aclr(aclr), .datain(datain), .data_en(data_en),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_port(cfg_port), .cfg_enable(cfg_enable),
        .pl_data(pl_data), .pl_en(pl_en), .pl_sof(pl_sof), .pl_eof(pl_eof),
        .pl_abort(pl_abort), .busy(busy), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {pl_en, pl_sof, pl_eof, pl_abort, busy, (pl_en != '0) ? pl_data : 8'h00};
    endfunction

    function automatic logic [15:0] pick_port();
        case ($urandom_range(0, 4))
            0:       return 16'd80;
            1:       return 16'd5000;
            2:       return 16'd7000;
            3:       return 16'd1234;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic cfg_write(input int a, input logic [15:0] port, input bit en);
        cfg_we     = 1'b1;
        cfg_addr   = AW'(a);
        cfg_port   = port;
        cfg_enable = en;
        @(posedge clock); #1;
        cfg_we     = 1'b0;
        men[a]     = en;
        mport[a]   = port;
    endtask

    // One datagram of n bytes followed by two idle cycles; optional table write at cycle wr_cyc.
    task automatic run_frame(input string tag, input logic [15:0] dst, input logic [15:0] len,
                             input int n, input int wr_cyc, input int wr_addr,
                             input logic [15:0] wr_port, input bit wr_en,
                             output int strobes, output logic [NCH-1:0] en_seen);
        logic [7:0]     b [$];
        bit             hit, complete, aborted, err_inc, drop_inc, xbusy;
        int             ch, p, e, ln;
        logic [NCH-1:0] xen;
        logic [7:0]     xd;
        logic [15:0]    expv;

        b = {};
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
        if (n > 2) b[2] = dst[15:8];
        if (n > 3) b[3] = dst[7:0];
        if (n > 4) b[4] = len[15:8];
        if (n > 5) b[5] = len[7:0];
        for (int i = 0; i < fixed_pl.size(); i++) if (8 + i < n) b[8 + i] = fixed_pl[i];

        if (wr_cyc >= 0 && wr_cyc < 3) begin
            men[wr_addr]   = wr_en;
            mport[wr_addr] = wr_port;
        end
        hit = 1'b0; ch = 0;
        for (int i = 0; i < NCH; i++) begin
            if (!hit && men[i] && mport[i] == dst) begin
                hit = 1'b1;
                ch  = i;
            end
        end
        if (wr_cyc >= 3) begin
            men[wr_addr]   = wr_en;
            mport[wr_addr] = wr_port;
        end

        ln = int'(len);
        p = 0; e = 0; complete = 0; aborted = 0; err_inc = 0; drop_inc = 0;
        if (n < 4)            err_inc = 1;
        else if (!hit)        drop_inc = 1;
        else if (n < 6)       err_inc = 1;
        else if (ln < 8)      err_inc = 1;
        else if (ln == 8)     ;
        else if (n < 8)       err_inc = 1;
        else begin
            p = ln - 8;
            if (n - 8 >= p) begin
                e = p; complete = 1;
            end else begin
                e = n - 8; aborted = 1; err_inc = 1;
            end
        end

        strobes = 0;
        en_seen = '0;
        for (int c = 0; c < n + 2; c++) begin
            datain     = (c < n) ? b[c] : 8'($urandom);
            data_en    = (c < n);
            cfg_we     = (c == wr_cyc);
            cfg_addr   = AW'(wr_addr);
            cfg_port   = wr_port;
            cfg_enable = wr_en;
            @(posedge clock); #1;
            cfg_we = 1'b0;
            xen   = (hit && c >= 8 && c - 8 < e) ? NCH'(1) << ch : '0;
            xd    = 8'h00;
            if (xen != '0) xd = b[c];
            xbusy = complete ? (c < 8 + p - 1) : (c < n);
            expv  = {xen, (xen != '0) && c == 8, (xen != '0) && complete && c == 8 + p - 1,
                     aborted && c == n, xbusy, xd};
            chk($sformatf("%s c%0d", tag, c), 32'(outs()), 32'(expv));
            if (pl_en != '0) strobes++;
            en_seen |= pl_en;
        end
        if (drop_inc && mdrop < MAXC) mdrop++;
        if (err_inc && merr < MAXC) merr++;
        chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'(mdrop));
        chk({tag, " err_cnt"}, 32'(err_cnt), 32'(merr));
    endtask

    initial begin
        int             st, n, ln, wr;
        logic [NCH-1:0] es;
        logic [15:0]    dst, len;
        logic [7:0]     fb [$];

        aclr = 1'b1; data_en = 1'b0; datain = 8'h00;
        cfg_we = 1'b0; cfg_addr = '0; cfg_port = '0; cfg_enable = 1'b0;
        for (int i = 0; i < NCH; i++) begin men[i] = 0; mport[i] = '0; end
        mdrop = 0; merr = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset outs", 32'(outs()), 32'h0);
        chk("reset cnts", 32'({drop_cnt, err_cnt}), 32'h0);
        aclr = 1'b0;
        @(posedge clock); #1;

        cfg_write(1, 16'd5000, 1'b1);
        fixed_pl = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_frame("len12", 16'd5000, 16'd12, 18, -1, 0, 16'd0, 1'b0, st, es);
        fixed_pl = {};
        chk("len12 strobes", 32'(st), 32'd4);
        chk("len12 chan", 32'(es), 32'b0010);

        run_frame("drop1", 16'd7000, 16'd12, 14, -1, 0, 16'd0, 1'b0, st, es);
        chk("drop1 cnt", 32'(drop_cnt), 32'd1);
        run_frame("drop2", 16'd7000, 16'd12, 14, -1, 0, 16'd0, 1'b0, st, es);
        chk("drop2 cnt", 32'(drop_cnt), 32'd2);
        chk("drop2 strobes", 32'(st), 32'd0);

        run_frame("len6", 16'd5000, 16'd6, 10, -1, 0, 16'd0, 1'b0, st, es);
        chk("len6 err", 32'(err_cnt), 32'd1);
        run_frame("len8", 16'd5000, 16'd8, 10, -1, 0, 16'd0, 1'b0, st, es);
        chk("len8 strobes", 32'(st), 32'd0);
        run_frame("len9", 16'd5000, 16'd9, 9, -1, 0, 16'd0, 1'b0, st, es);
        chk("len9 strobes", 32'(st), 32'd1);

        cfg_write(0, 16'd80, 1'b1);
        cfg_write(2, 16'd80, 1'b1);
        run_frame("dup", 16'd80, 16'd10, 10, -1, 0, 16'd0, 1'b0, st, es);
        chk("dup chan", 32'(es), 32'b0001);
        run_frame("wr_k3", 16'd80, 16'd10, 10, 3, 0, 16'd80, 1'b0, st, es);
        chk("wr_k3 chan", 32'(es), 32'b0001);
        run_frame("after_wr", 16'd80, 16'd10, 10, -1, 0, 16'd0, 1'b0, st, es);
        chk("after_wr chan", 32'(es), 32'b0100);

        run_frame("trunc", 16'd5000, 16'd20, 13, -1, 0, 16'd0, 1'b0, st, es);
        chk("trunc strobes", 32'(st), 32'd5);
        chk("trunc err", 32'(err_cnt), 32'd2);

        // aclr while payload byte 3 is on the input; the rest of the frame must be ignored
        cfg_write(3, 16'd1234, 1'b1);
        fb = {8'h01, 8'h02, 8'h04, 8'hD2, 8'h00, 8'd30, 8'h00, 8'h00};
        for (int i = 0; i < 13; i++) fb.push_back(8'($urandom));
        for (int c = 0; c < 21; c++) begin
            datain  = fb[c];
            data_en = 1'b1;
            if (c == 11) begin
                aclr = 1'b1;
                #1;
                chk("aclr outs", 32'(outs()), 32'h0);
                chk("aclr cnts", 32'({drop_cnt, err_cnt}), 32'h0);
                #2;
                aclr = 1'b0;
            end
            @(posedge clock); #1;
            if (c >= 8 && c < 11) chk($sformatf("pre_aclr c%0d", c), 32'(outs()),
                                      32'({4'b1000, c == 8, 1'b0, 1'b0, 1'b1, fb[c]}));
            if (c >= 11) chk($sformatf("wait c%0d", c), 32'(outs()), 32'h0);
        end
        data_en = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
            chk("wait tail", 32'(outs()), 32'h0);
        end
        for (int i = 0; i < NCH; i++) begin men[i] = 0; mport[i] = '0; end
        mdrop = 0; merr = 0;
        run_frame("tbl_clr", 16'd5000, 16'd12, 14, -1, 0, 16'd0, 1'b0, st, es);
        chk("tbl_clr drop", 32'(drop_cnt), 32'd1);
        cfg_write(3, 16'd1234, 1'b1);
        run_frame("rewrite", 16'd1234, 16'd12, 14, -1, 0, 16'd0, 1'b0, st, es);
        chk("rewrite strobes", 32'(st), 32'd4);
        chk("rewrite chan", 32'(es), 32'b1000);

        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 1) == 1)
                cfg_write($urandom_range(0, NCH - 1), pick_port(), $urandom_range(0, 3) != 0);
            dst = pick_port();
            case ($urandom_range(0, 9))
                0:       len = 16'($urandom_range(0, 7));
                1:       len = 16'd8;
                default: len = 16'($urandom_range(9, 30));
            endcase
            ln = (int'(len) > 8) ? int'(len) : 8;
            if ($urandom_range(0, 3) == 0) n = $urandom_range(1, ln + 2);
            else                           n = ln + $urandom_range(0, 4);
            wr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            run_frame($sformatf("rnd%0d", f), dst, len, n, wr, $urandom_range(0, NCH - 1),
                      pick_port(), $urandom_range(0, 1) == 1, st, es);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
